hazard_bubble_stage: RTL and testbench
======================================

Name: hazard_bubble_stage

Overview:
- Parametrised successor to the ID-stage NOP mux.
- Registers the ID-stage control bundle into the ID/EX control register. Replaces the bundle with a configurable NOP bundle on load-use stalls and branch flushes.
- Supports multi-cycle stalls via an internal down-counter, and drives the PC and IF/ID write enables.
- Sits between the Control Unit/Hazard Unit and the ID/EX pipeline register. Also keeps a saturating bubble-count performance counter.

Parameters:
- CTRL_W, 10, width of the control bundle {RegWrite,Branch_en,MemWrite,MemRead,MemtoReg[1:0],ALUOp[1:0],ALUSrc[1:0]}.
- NOP_CTRL, 10'h000, control bundle injected as a bubble. Width CTRL_W; RegWrite, MemWrite and Branch_en must be 0.
- STALL_CNT_W, 2, width of the stall-length request (max stall = 2^STALL_CNT_W - 1 cycles).
- PERF_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ip_ctrl  in  CTRL_W  control bundle from the Control Unit for the instruction in ID.
- ip_stall_req  in  1  Hazard Unit stall request (load-use or multi-cycle op).
- ip_stall_cycles  in  STALL_CNT_W  requested stall length; 0 is treated as 1.
- ip_flush  in  1  branch taken / redirect: squash the ID instruction.
- op_ctrl_ex  out  CTRL_W  registered ID/EX control bundle.
- op_ex_bubble  out  1  registered; 1 when op_ctrl_ex holds an injected NOP.
- op_pc_write_en  out  1  combinational; 0 freezes the PC.
- op_ifid_write_en  out  1  combinational; 0 freezes IF/ID.
- op_stall_active  out  1  combinational; 1 in any cycle the front end is held.
- op_bubble_cnt  out  PERF_W  saturating count of injected bubbles.

Behaviour:
- States: RUN, STALL. Internal remain counter is STALL_CNT_W bits.
- Reset (asynchronous, any time including mid-stall) sets:
  - state=RUN, remain=0;
  - op_ctrl_ex=NOP_CTRL, op_ex_bubble=1, op_bubble_cnt=0.
- Combinational hold: hold = (state==STALL) | (state==RUN & ip_stall_req & ~ip_flush).
  - op_stall_active = hold.
  - op_pc_write_en = op_ifid_write_en = ~hold.
- RUN, ip_flush=1 (overrides ip_stall_req):
  - next op_ctrl_ex=NOP_CTRL, op_ex_bubble=1, stay RUN.
  - PC write stays enabled so the redirect target can load.
- RUN, ip_stall_req=1, ip_flush=0, with N = max(ip_stall_cycles,1):
  - inject NOP this edge.
  - If N==1, stay RUN. Else go to STALL with remain=N-1.
- RUN, no request:
  - op_ctrl_ex <= ip_ctrl, op_ex_bubble <= 0.
- STALL:
  - inject NOP each edge and decrement remain; at remain==1 return to RUN.
  - ip_stall_req is ignored; no re-trigger or extension.
- STALL, ip_flush=1:
  - abort the stall: inject NOP, go to RUN, remain=0.
  - hold is still 1 in that cycle (state==STALL).
- Net effect: a request of N gives exactly N consecutive hold cycles and N bubbles. ip_ctrl is captured on the first edge after hold falls.
- op_bubble_cnt increments by 1 on every edge that injects a NOP, for any cause. It saturates at 2^PERF_W-1 and never wraps.
- Latency:
  - op_ctrl_ex: 1 cycle from ip_ctrl.
  - write enables: 0 cycles (same cycle as the request).
- No X propagation: ip_ctrl is ignored whenever a NOP is injected.

Decomposition:
- Shared pipeline package holds:
  - the CTRL_W default;
  - the NOP_CTRL constant (matching the ADDI x0,x0,0 / 0x00000013 decode);
  - bit-index localparams for the control bundle fields;
  - the state encoding RUN=1'b0, STALL=1'b1.
- One natural sub-module: sat_counter (parametrised width, increment enable, async reset), used for op_bubble_cnt.
- FSM, remain counter and control register live in the top module.

Test Plan:
- Reset: assert rst mid-stall (remain=2, STALL) -> op_ctrl_ex=10'h000, op_ex_bubble=1, op_pc_write_en=1, op_bubble_cnt=0 immediately, without waiting for a clock edge.
- Pass-through: ip_ctrl=10'h3A5 with no requests -> op_ctrl_ex=10'h3A5 one edge later, op_ex_bubble=0, both write enables high.
- Multi-cycle stall: ip_stall_req=1 with ip_stall_cycles=3 at cycle t, ip_ctrl=10'h2C1 ->
  - op_pc_write_en=0 in cycles t..t+2;
  - op_ctrl_ex=NOP after edges t, t+1, t+2;
  - op_ctrl_ex=10'h2C1 after edge t+3;
  - op_bubble_cnt=3.
- Zero-length request: ip_stall_cycles=0 -> exactly 1 hold cycle and 1 bubble.
- Flush priority: ip_flush=1 and ip_stall_req=1 together in RUN -> op_pc_write_en=1, one bubble, no STALL entry.
  - Flush in the 2nd cycle of a 3-cycle stall -> hold in that cycle, RUN next cycle, 2 bubbles total.
- Saturation with PERF_W=4: stall_req held continuously with cycles=1 for 20 cycles -> op_bubble_cnt stops at 15.

Source files
------------

// File: rtl/hazard_bubble_stage_pkg.sv
// hazard_bubble_stage_pkg: shared pipeline definitions for the ID/EX control bundle and bubble stage
// Contents: default bundle width, NOP bundle, control field bit positions, bubble-stage state encoding.
package hazard_bubble_stage_pkg;

    localparam int CTRL_W_DEF = 10;

    // ADDI x0,x0,0 (0x00000013) writes x0, so no architectural side effect: every enable cleared.
    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

    localparam int REG_WRITE_BIT  = 9;
    localparam int BRANCH_EN_BIT  = 8;
    localparam int MEM_WRITE_BIT  = 7;
    localparam int MEM_READ_BIT   = 6;
    localparam int MEM_TO_REG_LSB = 4;
    localparam int ALU_OP_LSB     = 2;
    localparam int ALU_SRC_LSB    = 0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_bubble_stage_sat_counter.sv
// sat_counter: saturating up-counter with increment enable and asynchronous reset
// Ports: clk, rst (async, active-high), en (increment), cnt (current count, holds at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en && !(&cnt))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hazard_bubble_stage.sv
// hazard_bubble_stage: ID/EX control register with NOP-bubble injection for stalls and flushes
// Ports: clk, rst (async, active-high); ip_ctrl, ip_stall_req, ip_stall_cycles, ip_flush in;
//        op_ctrl_ex, op_ex_bubble (registered), op_pc_write_en, op_ifid_write_en,
//        op_stall_active (combinational), op_bubble_cnt (saturating bubble count).
module hazard_bubble_stage
    import hazard_bubble_stage_pkg::*;
#(
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_CTRL    = CTRL_W'(NOP_CTRL_DEF),
    parameter int                STALL_CNT_W = 2,
    parameter int                PERF_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CTRL_W-1:0]      ip_ctrl,
    input  logic                   ip_stall_req,
    input  logic [STALL_CNT_W-1:0] ip_stall_cycles,
    input  logic                   ip_flush,
    output logic [CTRL_W-1:0]      op_ctrl_ex,
    output logic                   op_ex_bubble,
    output logic                   op_pc_write_en,
    output logic                   op_ifid_write_en,
    output logic                   op_stall_active,
    output logic [PERF_W-1:0]      op_bubble_cnt
);

    localparam logic [STALL_CNT_W-1:0] ONE = STALL_CNT_W'(1);

    state_t                 state, state_n;
    logic [STALL_CNT_W-1:0] remain, remain_n, n_req;
    logic                   hold, inject;

    // The first hold cycle is spent in RUN, so STALL only covers the remaining N-1 cycles.
    always_comb begin
        n_req    = (ip_stall_cycles == '0) ? ONE : ip_stall_cycles;
        hold     = (state == STALL) | (ip_stall_req & ~ip_flush);
        inject   = (state == STALL) | ip_stall_req | ip_flush;
        state_n  = RUN;
        remain_n = '0;
        if (state == STALL) begin
            if (!ip_flush && remain > ONE) begin
                state_n  = STALL;
                remain_n = remain - ONE;
            end
        end else if (ip_stall_req && !ip_flush && n_req > ONE) begin
            state_n  = STALL;
            remain_n = n_req - ONE;
        end
    end

    assign op_stall_active  = hold;
    assign op_pc_write_en   = ~hold;
    assign op_ifid_write_en = ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            remain       <= '0;
            op_ctrl_ex   <= NOP_CTRL;
            op_ex_bubble <= 1'b1;
        end else begin
            state        <= state_n;
            remain       <= remain_n;
            op_ctrl_ex   <= inject ? NOP_CTRL : ip_ctrl;
            op_ex_bubble <= inject;
        end
    end

    sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .en  (inject),
        .cnt (op_bubble_cnt)
    );

endmodule

// File: tb/tb_hazard_bubble_stage.sv
// tb_hazard_bubble_stage: directed and random checks of hazard_bubble_stage against a cycle-count model
module tb_hazard_bubble_stage;

    localparam int PERF_W  = 4;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] ip_ctrl = '0;
    logic       ip_stall_req = 1'b0;
    logic [1:0] ip_stall_cycles = '0;
    logic       ip_flush = 1'b0;
    logic [9:0] op_ctrl_ex;
    logic       op_ex_bubble, op_pc_write_en, op_ifid_write_en, op_stall_active;
    logic [PERF_W-1:0] op_bubble_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: number of further forced-hold cycles still owed, plus expected outputs.
    int         owed = 0;
    logic [9:0] m_ctrl = '0;
    logic       m_bubble = 1'b1;
    int         m_cnt = 0;

    hazard_bubble_stage #(.PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ip_ctrl          (ip_ctrl),
        .ip_stall_req     (ip_stall_req),
        .ip_stall_cycles  (ip_stall_cycles),
        .ip_flush         (ip_flush),
        .op_ctrl_ex       (op_ctrl_ex),
        .op_ex_bubble     (op_ex_bubble),
        .op_pc_write_en   (op_pc_write_en),
        .op_ifid_write_en (op_ifid_write_en),
        .op_stall_active  (op_stall_active),
        .op_bubble_cnt    (op_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owed     = 0;
        m_ctrl   = '0;
        m_bubble = 1'b1;
        m_cnt    = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ctrl"}, 32'(op_ctrl_ex), 32'(m_ctrl));
        chk({tag, ".bubble"}, 32'(op_ex_bubble), 32'(m_bubble));
        chk({tag, ".cnt"}, 32'(op_bubble_cnt), 32'(m_cnt));
    endtask

    // One cycle: drive at negedge, check front-end enables, clock, check registered outputs.
    task automatic step(input string tag, input logic [9:0] ctrl, input logic req,
                        input int cyc, input logic flush);
        logic exp_hold, inj;
        int   n;
        ip_ctrl         = ctrl;
        ip_stall_req    = req;
        ip_stall_cycles = 2'(cyc);
        ip_flush        = flush;
        exp_hold = (owed > 0) || (req && !flush);
        #1;
        chk({tag, ".pc_we"}, 32'(op_pc_write_en), 32'(!exp_hold));
        chk({tag, ".ifid_we"}, 32'(op_ifid_write_en), 32'(!exp_hold));
        chk({tag, ".stall_active"}, 32'(op_stall_active), 32'(exp_hold));
        inj = (owed > 0) || req || flush;
        n   = (cyc == 0) ? 1 : cyc;
        if (owed > 0)
            owed = flush ? 0 : owed - 1;
        else if (req && !flush)
            owed = n - 1;
        m_ctrl   = inj ? 10'h000 : ctrl;
        m_bubble = inj;
        m_cnt    = (inj && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        @(posedge clk);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        chk("reset.pc_we", 32'(op_pc_write_en), 32'(1));
        rst = 1'b0;

        step("pass", 10'h3A5, 1'b0, 0, 1'b0);

        step("stall3.c0", 10'h2C1, 1'b1, 3, 1'b0);
        step("stall3.c1", 10'h2C1, 1'b0, 0, 1'b0);
        step("stall3.c2", 10'h2C1, 1'b0, 0, 1'b0);
        step("stall3.cap", 10'h2C1, 1'b0, 0, 1'b0);
        chk("stall3.total", 32'(op_bubble_cnt), 32'(3));

        step("zero.c0", 10'h155, 1'b1, 0, 1'b0);
        step("zero.cap", 10'h155, 1'b0, 0, 1'b0);

        step("flushpri", 10'h0F0, 1'b1, 3, 1'b1);
        step("flushpri.cap", 10'h0F1, 1'b0, 0, 1'b0);

        step("abort.c0", 10'h111, 1'b1, 3, 1'b0);
        step("abort.c1", 10'h111, 1'b1, 3, 1'b1);
        step("abort.cap", 10'h222, 1'b0, 0, 1'b0);

        for (int i = 0; i < 200; i++)
            step("rand", 10'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));

        step("rstmid.c0", 10'h333, 1'b1, 3, 1'b0);
        ip_stall_req = 1'b0;
        ip_flush     = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_regs("rstmid");
        chk("rstmid.pc_we", 32'(op_pc_write_en), 32'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            step("sat", 10'($urandom), 1'b1, 1, 1'b0);
        chk("sat.final", 32'(op_bubble_cnt), 32'(CNT_MAX));
        step("sat.cap", 10'h2AA, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
